// File: rtl/ahb_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_sequencer
// Purpose  : Master-side AHB address-phase sequencer for the AXI-to-AHB
//            bridge. Takes one AXI-style burst command at a time, drives the
//            AHB address/control phase of each beat, and tracks data-phase
//            completion through HREADY/HRESP.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            cmd_valid/cmd_ready      - command handshake
//            cmd_addr/len/size/burst/write - AXI-style burst command
//            haddr/htrans/hburst/hsize/hwrite - AHB address phase (registered)
//            hready/hresp             - AHB transfer ready / error response
//            beat_done/beat_last      - per-beat completion, last qualifier
//            err_pulse                - rejected command or ERROR abort
//            busy                     - burst in progress
// Revision : 1.0 - initial release
// ============================================================================
module ahb_burst_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int MAX_SIZE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic              cmd_write,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    output logic              hwrite,
    input  logic              hready,
    input  logic              hresp,
    output logic              beat_done,
    output logic              beat_last,
    output logic              err_pulse,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR      = 2'd1,
        S_DATA_LAST = 2'd2,
        S_ERR       = 2'd3
    } state_t;

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] C_HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] C_BURST_FIXED   = 2'b00;
    localparam logic [1:0] C_BURST_INCR    = 2'b01;
    localparam logic [1:0] C_BURST_WRAP    = 2'b10;
    localparam logic [ADDR_W-1:0] C_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        len_q, len_d;
    logic [1:0]        burst_q, burst_d;
    logic [3:0]        beat_q, beat_d;
    logic              outst_q, outst_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [2:0]        hsize_q, hsize_d;
    logic              hwrite_q, hwrite_d;
    logic              beat_done_q, beat_done_d;
    logic              beat_last_q, beat_last_d;
    logic              err_pulse_q, err_pulse_d;
    logic              busy_q, busy_d;

    // ---------------- command decode ----------------
    logic        w_len_pow2m1;
    logic        w_cmd_illegal;
    logic [11:0] w_cmd_end_off;
    logic        w_cmd_crosses;
    logic [2:0]  w_cmd_hburst;

    assign w_len_pow2m1  = (cmd_len == 4'd3) || (cmd_len == 4'd7) || (cmd_len == 4'd15);
    assign w_cmd_illegal = (cmd_burst == 2'b11) ||
                           (cmd_size > 3'(MAX_SIZE)) ||
                           ((cmd_burst == C_BURST_WRAP) && !w_len_pow2m1);

    // Page offset of the last beat; any carry into bit 10 or above means the
    // burst leaves its starting 1 KB page.
    assign w_cmd_end_off = {2'b00, cmd_addr[9:0]} + ({8'd0, cmd_len} << cmd_size);
    assign w_cmd_crosses = |w_cmd_end_off[11:10];

    always_comb begin
        w_cmd_hburst = 3'b000;
        if (cmd_burst == C_BURST_WRAP) begin
            if (cmd_len == 4'd3)       w_cmd_hburst = 3'b010;
            else if (cmd_len == 4'd7)  w_cmd_hburst = 3'b100;
            else if (cmd_len == 4'd15) w_cmd_hburst = 3'b110;
        end else if (cmd_burst == C_BURST_INCR) begin
            w_cmd_hburst = 3'b001;
            if (!w_cmd_crosses) begin
                if (cmd_len == 4'd3)       w_cmd_hburst = 3'b011;
                else if (cmd_len == 4'd7)  w_cmd_hburst = 3'b101;
                else if (cmd_len == 4'd15) w_cmd_hburst = 3'b111;
            end
        end
    end

    // ---------------- next-beat address ----------------
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_wrap_mask;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W-1:0] w_next_addr;
    logic [1:0]        w_next_htrans;

    assign w_inc       = C_ONE << hsize_q;
    assign w_wrap_mask = (({{(ADDR_W-4){1'b0}}, len_q} + C_ONE) << hsize_q) - C_ONE;
    assign w_addr_inc  = haddr_q + w_inc;

    always_comb begin
        w_next_addr   = w_addr_inc;
        w_next_htrans = C_HTRANS_SEQ;
        if (burst_q == C_BURST_FIXED) begin
            w_next_addr   = haddr_q;
            w_next_htrans = C_HTRANS_NONSEQ;
        end else if (burst_q == C_BURST_WRAP) begin
            w_next_addr = (haddr_q & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
        end else if (w_addr_inc[9:0] == 10'd0) begin
            // INCR beat opening a new 1 KB page restarts the transfer
            w_next_htrans = C_HTRANS_NONSEQ;
        end
    end

    // ---------------- FSM next-state ----------------
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        outst_d     = outst_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hburst_d    = hburst_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        beat_done_d = 1'b0;
        beat_last_d = 1'b0;
        err_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (w_cmd_illegal) begin
                        err_pulse_d = 1'b1;
                    end else begin
                        state_d  = S_ADDR;
                        len_d    = cmd_len;
                        burst_d  = cmd_burst;
                        beat_d   = 4'd0;
                        outst_d  = 1'b0;
                        haddr_d  = cmd_addr;
                        htrans_d = C_HTRANS_NONSEQ;
                        hburst_d = w_cmd_hburst;
                        hsize_d  = cmd_size;
                        hwrite_d = cmd_write;
                    end
                end
            end
            S_ADDR, S_DATA_LAST: begin
                if (outst_q && hresp && !hready) begin
                    // First ERROR cycle: cancel the pending address phase
                    state_d  = S_ERR;
                    htrans_d = C_HTRANS_IDLE;
                    outst_d  = 1'b0;
                end else if (hready) begin
                    if (outst_q && hresp) begin
                        // ERROR seen without the leading wait cycle
                        err_pulse_d = 1'b1;
                        state_d     = S_IDLE;
                        htrans_d    = C_HTRANS_IDLE;
                        outst_d     = 1'b0;
                    end else begin
                        beat_done_d = outst_q;
                        if (state_q == S_DATA_LAST) begin
                            beat_last_d = outst_q;
                            state_d     = S_IDLE;
                            outst_d     = 1'b0;
                        end else begin
                            // Current address phase accepted; its data phase
                            // is now the outstanding one.
                            outst_d = 1'b1;
                            if (beat_q == len_q) begin
                                state_d  = S_DATA_LAST;
                                htrans_d = C_HTRANS_IDLE;
                            end else begin
                                beat_d   = beat_q + 4'd1;
                                haddr_d  = w_next_addr;
                                htrans_d = w_next_htrans;
                            end
                        end
                    end
                end
            end
            S_ERR: begin
                if (hready) begin
                    err_pulse_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= 4'd0;
            burst_q     <= 2'd0;
            beat_q      <= 4'd0;
            outst_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= C_HTRANS_IDLE;
            hburst_q    <= 3'd0;
            hsize_q     <= 3'd0;
            hwrite_q    <= 1'b0;
            beat_done_q <= 1'b0;
            beat_last_q <= 1'b0;
            err_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            outst_q     <= outst_d;
            cmd_ready_q <= cmd_ready_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hburst_q    <= hburst_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            beat_done_q <= beat_done_d;
            beat_last_q <= beat_last_d;
            err_pulse_q <= err_pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hburst    = hburst_q;
    assign hsize     = hsize_q;
    assign hwrite    = hwrite_q;
    assign beat_done = beat_done_q;
    assign beat_last = beat_last_q;
    assign err_pulse = err_pulse_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_burst_sequencer
// Purpose  : Directed self-checking bench for ahb_burst_sequencer with
//            hand-computed expected address/control sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_burst_sequencer;

    localparam int ADDR_W = 32;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic [2:0]        cmd_size;
    logic [1:0]        cmd_burst;
    logic              cmd_write;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hwrite;
    logic              hready;
    logic              hresp;
    logic              beat_done;
    logic              beat_last;
    logic              err_pulse;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int bd_cnt   = 0;
    int bl_cnt   = 0;
    int err_cnt  = 0;
    int bd0, bl0, err0;

    ahb_burst_sequencer #(.ADDR_W(ADDR_W), .MAX_SIZE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .cmd_write (cmd_write),
        .haddr     (haddr),
        .htrans    (htrans),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hready    (hready),
        .hresp     (hresp),
        .beat_done (beat_done),
        .beat_last (beat_last),
        .err_pulse (err_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (beat_done) bd_cnt  <= bd_cnt + 1;
        if (beat_last) bl_cnt  <= bl_cnt + 1;
        if (err_pulse) err_cnt <= err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [31:0] a, input logic [1:0] t);
        check_eq({tag, ".haddr"}, 64'(haddr), 64'(a));
        check_eq({tag, ".htrans"}, 64'(htrans), 64'(t));
    endtask

    task automatic chk_all_zero(input string tag);
        check_eq({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd0);
        check_eq({tag, ".haddr"},     64'(haddr),     64'd0);
        check_eq({tag, ".htrans"},    64'(htrans),    64'd0);
        check_eq({tag, ".hburst"},    64'(hburst),    64'd0);
        check_eq({tag, ".hsize"},     64'(hsize),     64'd0);
        check_eq({tag, ".hwrite"},    64'(hwrite),    64'd0);
        check_eq({tag, ".beat_done"}, 64'(beat_done), 64'd0);
        check_eq({tag, ".beat_last"}, 64'(beat_last), 64'd0);
        check_eq({tag, ".err_pulse"}, 64'(err_pulse), 64'd0);
        check_eq({tag, ".busy"},      64'(busy),      64'd0);
    endtask

    // Presents a command for one cycle; returns in the cycle after acceptance
    task automatic send_cmd(input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic wr);
        cmd_addr  = a;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_write = wr;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0x1 expected 0x0");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        cmd_burst = '0; cmd_write = 1'b0; hready = 1'b1; hresp = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        check_eq("reset.cmd_ready_after", 64'(cmd_ready), 64'd1);

        // ---- INCR4 @0x100, write ----
        bd0 = bd_cnt; bl0 = bl_cnt;
        send_cmd(32'h100, 4'd3, 3'd2, 2'b01, 1'b1);
        check_eq("incr4.hburst", 64'(hburst), 64'h3);
        check_eq("incr4.hsize",  64'(hsize),  64'h2);
        check_eq("incr4.hwrite", 64'(hwrite), 64'h1);
        check_eq("incr4.busy",   64'(busy),   64'h1);
        check_eq("incr4.cmd_ready_low", 64'(cmd_ready), 64'h0);
        chk_bus("incr4.b0", 32'h100, T_NSEQ); tick();
        chk_bus("incr4.b1", 32'h104, T_SEQ);
        check_eq("incr4.no_done_yet", 64'(beat_done), 64'h0); tick();
        chk_bus("incr4.b2", 32'h108, T_SEQ);
        check_eq("incr4.done0", 64'(beat_done), 64'h1); tick();
        chk_bus("incr4.b3", 32'h10C, T_SEQ); tick();
        check_eq("incr4.drain_htrans", 64'(htrans), 64'(T_IDLE));
        check_eq("incr4.drain_busy", 64'(busy), 64'h1);
        check_eq("incr4.drain_cmd_ready", 64'(cmd_ready), 64'h0); tick();
        check_eq("incr4.last", 64'(beat_last), 64'h1);
        check_eq("incr4.last_done", 64'(beat_done), 64'h1);
        check_eq("incr4.cmd_ready", 64'(cmd_ready), 64'h1);
        check_eq("incr4.busy_low", 64'(busy), 64'h0); tick();
        check_eq("incr4.done_count", 64'(bd_cnt - bd0), 64'd4);
        check_eq("incr4.last_count", 64'(bl_cnt - bl0), 64'd1);

        // ---- WRAP4 @0x108, read ----
        send_cmd(32'h108, 4'd3, 3'd2, 2'b10, 1'b0);
        check_eq("wrap4.hburst", 64'(hburst), 64'h2);
        check_eq("wrap4.hwrite", 64'(hwrite), 64'h0);
        chk_bus("wrap4.b0", 32'h108, T_NSEQ); tick();
        chk_bus("wrap4.b1", 32'h10C, T_SEQ);  tick();
        chk_bus("wrap4.b2", 32'h100, T_SEQ);  tick();
        chk_bus("wrap4.b3", 32'h104, T_SEQ);  tick(); tick();
        check_eq("wrap4.last", 64'(beat_last), 64'h1); tick();

        // ---- illegal commands ----
        err0 = err_cnt;
        send_cmd(32'h200, 4'd2, 3'd2, 2'b10, 1'b0);
        check_eq("wrap3_illegal.err", 64'(err_pulse), 64'h1);
        check_eq("wrap3_illegal.htrans", 64'(htrans), 64'(T_IDLE));
        check_eq("wrap3_illegal.busy", 64'(busy), 64'h0);
        check_eq("wrap3_illegal.cmd_ready", 64'(cmd_ready), 64'h1); tick();
        check_eq("wrap3_illegal.err_clear", 64'(err_pulse), 64'h0);
        send_cmd(32'h200, 4'd0, 3'd3, 2'b01, 1'b0);
        check_eq("size3_illegal.err", 64'(err_pulse), 64'h1);
        check_eq("size3_illegal.htrans", 64'(htrans), 64'(T_IDLE)); tick();
        send_cmd(32'h200, 4'd0, 3'd2, 2'b11, 1'b0);
        check_eq("burst11_illegal.err", 64'(err_pulse), 64'h1); tick();
        check_eq("illegal.err_count", 64'(err_cnt - err0), 64'd3);

        // ---- INCR4 crossing 1 KB ----
        send_cmd(32'h3F8, 4'd3, 3'd2, 2'b01, 1'b1);
        check_eq("cross.hburst", 64'(hburst), 64'h1);
        chk_bus("cross.b0", 32'h3F8, T_NSEQ); tick();
        chk_bus("cross.b1", 32'h3FC, T_SEQ);  tick();
        chk_bus("cross.b2", 32'h400, T_NSEQ); tick();
        chk_bus("cross.b3", 32'h404, T_SEQ);  tick(); tick(); tick();

        // ---- INCR8 with 2-cycle stall on beat 3 ----
        bd0 = bd_cnt;
        send_cmd(32'h200, 4'd7, 3'd2, 2'b01, 1'b0);
        check_eq("stall.hburst", 64'(hburst), 64'h5);
        chk_bus("stall.b0", 32'h200, T_NSEQ); tick();
        chk_bus("stall.b1", 32'h204, T_SEQ);  tick();
        chk_bus("stall.b2", 32'h208, T_SEQ);
        hready = 1'b0; tick();
        chk_bus("stall.hold1", 32'h208, T_SEQ);
        check_eq("stall.no_done", 64'(beat_done), 64'h0); tick();
        chk_bus("stall.hold2", 32'h208, T_SEQ);
        hready = 1'b1; tick();
        chk_bus("stall.b3", 32'h20C, T_SEQ); tick();
        chk_bus("stall.b4", 32'h210, T_SEQ); tick();
        chk_bus("stall.b5", 32'h214, T_SEQ); tick();
        chk_bus("stall.b6", 32'h218, T_SEQ); tick();
        chk_bus("stall.b7", 32'h21C, T_SEQ); tick(); tick();
        check_eq("stall.last", 64'(beat_last), 64'h1); tick();
        check_eq("stall.done_count", 64'(bd_cnt - bd0), 64'd8);

        // ---- INCR8 aborted by ERROR on beat 2 ----
        bd0 = bd_cnt; err0 = err_cnt;
        send_cmd(32'h300, 4'd7, 3'd2, 2'b01, 1'b1);
        chk_bus("err.b0", 32'h300, T_NSEQ); tick();
        chk_bus("err.b1", 32'h304, T_SEQ);  tick();
        chk_bus("err.b2", 32'h308, T_SEQ);
        hresp = 1'b1; hready = 1'b0; tick();
        check_eq("err.htrans_idle", 64'(htrans), 64'(T_IDLE));
        check_eq("err.no_pulse_yet", 64'(err_pulse), 64'h0);
        check_eq("err.busy", 64'(busy), 64'h1);
        hready = 1'b1; tick();
        hresp = 1'b0;
        check_eq("err.pulse", 64'(err_pulse), 64'h1);
        check_eq("err.no_done", 64'(beat_done), 64'h0);
        check_eq("err.cmd_ready", 64'(cmd_ready), 64'h1);
        check_eq("err.htrans_still_idle", 64'(htrans), 64'(T_IDLE)); tick();
        check_eq("err.pulse_clear", 64'(err_pulse), 64'h0); tick(); tick();
        check_eq("err.no_more_addr", 64'(htrans), 64'(T_IDLE));
        check_eq("err.done_count", 64'(bd_cnt - bd0), 64'd1);
        check_eq("err.err_count", 64'(err_cnt - err0), 64'd1);

        // ---- FIXED len 1 @0x20 ----
        send_cmd(32'h20, 4'd1, 3'd2, 2'b00, 1'b0);
        check_eq("fixed.hburst", 64'(hburst), 64'h0);
        chk_bus("fixed.b0", 32'h20, T_NSEQ); tick();
        chk_bus("fixed.b1", 32'h20, T_NSEQ); tick(); tick();
        check_eq("fixed.last", 64'(beat_last), 64'h1); tick();

        // ---- reset in the middle of INCR16 ----
        send_cmd(32'h0, 4'd15, 3'd2, 2'b01, 1'b1);
        check_eq("rst16.hburst", 64'(hburst), 64'h7);
        chk_bus("rst16.b0", 32'h0, T_NSEQ); tick();
        chk_bus("rst16.b1", 32'h4, T_SEQ);  tick();
        chk_bus("rst16.b2", 32'h8, T_SEQ);
        rst = 1'b1; tick();
        chk_all_zero("rst16.reset");
        rst = 1'b0; tick();
        check_eq("rst16.cmd_ready", 64'(cmd_ready), 64'h1);
        check_eq("rst16.htrans", 64'(htrans), 64'(T_IDLE));
        bd0 = bd_cnt;
        tick(); tick(); tick();
        check_eq("rst16.no_done", 64'(bd_cnt - bd0), 64'd0);
        check_eq("rst16.idle_after", 64'(htrans), 64'(T_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
